// File: rtl/input_conditioner.sv
// Synchronise, debounce and edge-detect the raw update button and value switch.
// Define VALUE_LATCH_EN to hold value_clean steady between update steps.
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_WIDTH       = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic update_raw,
    input  logic value_raw,
    output logic update_clean,
    output logic update_pulse,
    output logic value_clean
);

    // Bit 1 of the state encoding is the clean level of the channel.
    localparam logic [1:0] STABLE_LOW  = 2'b00;
    localparam logic [1:0] PEND_HIGH   = 2'b01;
    localparam logic [1:0] PEND_LOW    = 2'b10;
    localparam logic [1:0] STABLE_HIGH = 2'b11;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [1:0]           sync1_q;
    logic [1:0]           sync2_q;
    logic [1:0]           state_q [2];
    logic [1:0]           state_d [2];
    logic [CNT_WIDTH-1:0] cnt_q   [2];
    logic [CNT_WIDTH-1:0] cnt_d   [2];
    logic                 pulse_q;
    logic                 pulse_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= {value_raw, update_raw};
            sync2_q <= sync1_q;
        end
    end

    // Channel 0 is update, channel 1 is value; both share the same rules.
    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            state_d[ch] = state_q[ch];
            cnt_d[ch]   = '0;
            unique case (state_q[ch])
                STABLE_LOW: begin
                    if (sync2_q[ch]) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_d[ch] = STABLE_HIGH;
                        end else begin
                            state_d[ch] = PEND_HIGH;
                            cnt_d[ch]   = CNT_ONE;
                        end
                    end
                end
                PEND_HIGH: begin
                    if (!sync2_q[ch]) begin
                        state_d[ch] = STABLE_LOW;
                    end else if (cnt_q[ch] == CNT_MAX) begin
                        state_d[ch] = STABLE_HIGH;
                    end else begin
                        cnt_d[ch] = cnt_q[ch] + CNT_ONE;
                    end
                end
                STABLE_HIGH: begin
                    if (!sync2_q[ch]) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_d[ch] = STABLE_LOW;
                        end else begin
                            state_d[ch] = PEND_LOW;
                            cnt_d[ch]   = CNT_ONE;
                        end
                    end
                end
                PEND_LOW: begin
                    if (sync2_q[ch]) begin
                        state_d[ch] = STABLE_HIGH;
                    end else if (cnt_q[ch] == CNT_MAX) begin
                        state_d[ch] = STABLE_LOW;
                    end else begin
                        cnt_d[ch] = cnt_q[ch] + CNT_ONE;
                    end
                end
            endcase
        end
    end

    assign pulse_d = ~state_q[0][1] & state_d[0][1];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int ch = 0; ch < 2; ch++) begin
                state_q[ch] <= STABLE_LOW;
                cnt_q[ch]   <= '0;
            end
            pulse_q <= 1'b0;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                state_q[ch] <= state_d[ch];
                cnt_q[ch]   <= cnt_d[ch];
            end
            pulse_q <= pulse_d;
        end
    end

    assign update_clean = state_q[0][1];
    assign update_pulse = pulse_q;

`ifdef VALUE_LATCH_EN
    // Sample the value level being committed on the same edge as the pulse.
    logic value_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= 1'b0;
        end else if (pulse_d) begin
            value_q <= state_d[1][1];
        end
    end

    assign value_clean = value_q;
`else
    assign value_clean = state_q[1][1];
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner with DEBOUNCE_CYCLES=4.
// Level checks are keyed by cycle; pulses are popped as they appear.
module tb_input_conditioner;

    logic clk = 1'b0;
    logic reset;
    logic update_raw;
    logic value_raw;
    logic update_clean;
    logic update_pulse;
    logic value_clean;

    input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .CNT_WIDTH(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .update_raw(update_raw),
        .value_raw(value_raw),
        .update_clean(update_clean),
        .update_pulse(update_pulse),
        .value_clean(value_clean)
    );

    always #5 clk = ~clk;

    // Bits are {update_pulse, value_clean, update_clean}.
    typedef struct {
        int       cyc;
        logic [2:0] mask;
        logic [2:0] val;
    } lvl_t;

    lvl_t lq[$];
    int   pq[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic lvl(input int c, input logic [2:0] m, input logic [2:0] v);
        lvl_t e;
        e.cyc  = c;
        e.mask = m;
        e.val  = v;
        lq.push_back(e);
    endtask

    task automatic at(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    always @(negedge clk) begin : monitor
        logic [2:0] act;
        int         e;
        act = {update_pulse, value_clean, update_clean};
        for (int i = lq.size() - 1; i >= 0; i--) begin
            if (lq[i].cyc == cyc) begin
                checks++;
                if ((act & lq[i].mask) !== (lq[i].val & lq[i].mask)) begin
                    errors++;
                    $display("FAIL level cyc=%0d got=%b want=%b mask=%b",
                             cyc, act, lq[i].val, lq[i].mask);
                end
                lq.delete(i);
            end
        end
        if (update_pulse === 1'b1) begin
            checks++;
            if (pq.size() == 0) begin
                errors++;
                $display("FAIL pulse cyc=%0d got=unexpected want=none", cyc);
            end else begin
                e = pq.pop_front();
                if (e != cyc) begin
                    errors++;
                    $display("FAIL pulse_cyc got=%0d want=%0d", cyc, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with the button already held.
        reset      = 1'b1;
        update_raw = 1'b1;
        value_raw  = 1'b0;
        for (int c = 1; c <= 3; c++) lvl(c, 3'b111, 3'b000);
        at(3);
        reset = 1'b0;
        lvl(8, 3'b111, 3'b000);
        lvl(9, 3'b111, 3'b101);
        lvl(10, 3'b111, 3'b001);
        pq.push_back(9);
        at(12);
        update_raw = 1'b0;
        lvl(17, 3'b111, 3'b001);
        lvl(18, 3'b111, 3'b000);

        // Clean press, long hold, release without pulse.
        at(22);
        update_raw = 1'b1;
        lvl(27, 3'b111, 3'b000);
        lvl(28, 3'b111, 3'b101);
        lvl(29, 3'b111, 3'b001);
        pq.push_back(28);
        at(42);
        update_raw = 1'b0;
        lvl(47, 3'b111, 3'b001);
        lvl(48, 3'b111, 3'b000);

        // Bounce 1,0,1,1,0,1 then hold.
        at(52); update_raw = 1'b1;
        at(53); update_raw = 1'b0;
        at(54); update_raw = 1'b1;
        at(55); update_raw = 1'b1;
        at(56); update_raw = 1'b0;
        at(57); update_raw = 1'b1;
        for (int c = 58; c <= 62; c++) lvl(c, 3'b111, 3'b000);
        lvl(63, 3'b111, 3'b101);
        lvl(64, 3'b111, 3'b001);
        pq.push_back(63);
        at(75);
        update_raw = 1'b0;
        lvl(80, 3'b111, 3'b001);
        lvl(81, 3'b111, 3'b000);

        // Value glitch of D-1 synchronised cycles.
        at(90); value_raw = 1'b1;
        at(93); value_raw = 1'b0;
        for (int c = 94; c <= 100; c++) lvl(c, 3'b111, 3'b000);

        // Value held, one press, then value drops without a press.
        at(105);
        value_raw = 1'b1;
`ifdef VALUE_LATCH_EN
        lvl(111, 3'b010, 3'b000);
        lvl(120, 3'b010, 3'b000);
`else
        lvl(110, 3'b010, 3'b000);
        lvl(111, 3'b010, 3'b010);
`endif
        at(115);
        update_raw = 1'b1;
        lvl(121, 3'b111, 3'b111);
        lvl(122, 3'b111, 3'b011);
        pq.push_back(121);
        at(125);
        update_raw = 1'b0;
        lvl(131, 3'b101, 3'b000);
        at(135);
        value_raw = 1'b0;
`ifdef VALUE_LATCH_EN
        lvl(141, 3'b010, 3'b010);
        lvl(145, 3'b010, 3'b010);
`else
        lvl(140, 3'b010, 3'b010);
        lvl(141, 3'b010, 3'b000);
        lvl(145, 3'b010, 3'b000);
`endif

        // Reset in the middle of a pending rise discards the count.
        at(150);
        update_raw = 1'b1;
        at(153);
        reset      = 1'b1;
        update_raw = 1'b0;
        lvl(154, 3'b111, 3'b000);
        lvl(155, 3'b111, 3'b000);
        at(155);
        reset = 1'b0;
        for (int c = 156; c <= 160; c++) lvl(c, 3'b111, 3'b000);

        // Simultaneous rise on both channels.
        at(165);
        update_raw = 1'b1;
        value_raw  = 1'b1;
        lvl(170, 3'b111, 3'b000);
        lvl(171, 3'b111, 3'b111);
        lvl(172, 3'b111, 3'b011);
        pq.push_back(171);
        at(180);
        update_raw = 1'b0;
        value_raw  = 1'b0;
        lvl(185, 3'b001, 3'b001);
        lvl(186, 3'b101, 3'b000);

        at(195);
        checks++;
        if (pq.size() != 0) begin
            errors++;
            $display("FAIL missing_pulses got=%0d want=0", pq.size());
        end
        checks++;
        if (lq.size() != 0) begin
            errors++;
            $display("FAIL unreached_levels got=%0d want=0", lq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
